snn_frame_ctrl: RTL and testbench
=================================

# snn_frame_ctrl

Frame-level controller for the SNN digit classifier. It unpacks received UART bytes LSB-first into the 1-bit input RAM, owns the RAM address mux between loader and `snn_core`, and pulses `start` when the 784-bit image is complete. It captures the classified digit onto the LEDs and hands its ASCII code to the UART transmitter. It also recovers from stalled or overrun frames.

## Interface
- `NUM_BITS`, 784: image bits per frame; must be a multiple of 8 (784 gives 98 bytes).
- `ADDR_W`, 10: RAM address width.
- `TIMEOUT`, 2_500_000: idle cycles allowed between bytes mid-frame (50 ms at 50 MHz).
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `rx_rdy` in 1: one-cycle pulse, `rx_data` valid.
- `rx_data` in 8: received byte.
- `ram_addr` out ADDR_W: input RAM address.
- `ram_wdata` out 1: RAM write bit.
- `ram_we` out 1: RAM write enable.
- `core_addr` in ADDR_W: read address from `snn_core`.
- `start` out 1: one-cycle pulse that launches `snn_core`.
- `done` in 1: one-cycle pulse from core, `digit` valid.
- `digit` in 4: classified digit.
- `tx_start` out 1: one-cycle pulse that launches the transmitter.
- `tx_data` out 8: byte to transmit.
- `tx_rdy` in 1: transmitter idle.
- `led` out 8: last classified digit.
- `busy` out 1: high whenever state is not IDLE.
- `frame_err` out 1: sticky; a frame timed out.
- `ovr_err` out 1: sticky; a byte arrived while not accepting.

## Operation
- Registers: `state`, `wr_ptr` (ADDR_W), `shreg` (8), `bit_cnt` (3), `idle_cnt` (≥22 bits), `led`, `tx_data`, and both error flags.
- States: IDLE, UNPACK, WAIT_BYTE, CALC, SEND.
- IDLE: `wr_ptr` = 0. On `rx_rdy`: load `shreg` ← `rx_data`, clear `frame_err` and `ovr_err`, go to UNPACK.
- UNPACK (exactly 8 cycles):
  - Each cycle drives `ram_we` = 1, `ram_addr` = `wr_ptr`, `ram_wdata` = `shreg[0]`.
  - Next edge: `shreg` >>= 1, `wr_ptr`++, `bit_cnt`++.
  - On the 8th cycle (`bit_cnt` = 7), if `wr_ptr` = NUM_BITS-1: pulse `start` combinationally in that same cycle and go to CALC. Otherwise go to WAIT_BYTE with `idle_cnt` = 0.
- WAIT_BYTE:
  - `rx_rdy` → load `shreg`, go to UNPACK; `wr_ptr` is retained.
  - Otherwise `idle_cnt`++. When it reaches TIMEOUT-1 with no `rx_rdy`: set `frame_err`, clear `wr_ptr`, go to IDLE.
  - If `rx_rdy` and the timeout coincide, `rx_rdy` wins.
- CALC: `ram_addr` = `core_addr`, `ram_we` = 0. On `done`: `led` ← {4'h0, `digit`}, `tx_data` ← 8'h30 + {4'h0, `digit`} (8-bit add, no clamp; digits 10–15 map to 0x3A–0x3F). Go to SEND.
- SEND: while `tx_rdy` = 0, hold. When `tx_rdy` = 1, pulse `tx_start` for one cycle, clear `wr_ptr`, go to IDLE.
- `rx_rdy` in UNPACK, CALC or SEND: the byte is dropped and `ovr_err` is set (sticky). Frame progress is unaffected.
- `ram_addr` = `wr_ptr` in every state except CALC.
- `ram_we`, `ram_wdata`, `start`, `tx_start` and `busy` are decoded from state.
- `done` outside CALC is ignored.

## Timing
- Reset (any state, mid-frame included): at the first edge with `rst` = 1, state → IDLE and all registers → 0, including `led`, `tx_data` and the error flags. All outputs are therefore 0 from that edge. A partial frame is discarded and the RAM contents are don't-care.
- `rx_rdy` to first RAM write: 1 cycle. One byte occupies 8 consecutive write cycles, addresses 8k..8k+7, with bit 0 at 8k.
- Last write (address NUM_BITS-1) and `start` occur in the same cycle. `ram_addr` follows `core_addr` from the next cycle.
- `done` to `led`/`tx_data` update: 1 edge.
- `tx_start` asserts 1 cycle after `done` if `tx_rdy` is already high. `tx_data` is stable while `tx_start` is high and until the next `done`.
- Back-to-back frames: a new first byte is accepted the cycle after `tx_start`.

## Test plan
- Full frame: 98 bytes, byte k = k[7:0], ~100 cycles apart → 784 writes where address a = bit (a%8) of byte a/8; single `start` in the cycle with `ram_addr` = 783; `busy` high from the first byte.
- Result path: in CALC drive `core_addr` = 0x155 → `ram_addr` = 0x155. Then `done` with `digit` = 7 and `tx_rdy` = 1 → next cycle `led` = 0x07, `tx_data` = 0x37; `tx_start` is 1 for one cycle; `busy` drops afterwards.
- TX backpressure: `done` with `digit` = 3 while `tx_rdy` = 0 for 50 cycles → no `tx_start` until `tx_rdy` rises, then exactly one pulse with `tx_data` = 0x33.
- Timeout (TIMEOUT = 100): 10 bytes, then silence → `frame_err` = 1 after 100 idle cycles, state IDLE. Next byte writes address 0 and clears `frame_err`.
- Overrun: `rx_rdy` during UNPACK and during CALC → `ovr_err` = 1, `wr_ptr` unchanged, `start` still after exactly 98 accepted bytes.
- Reset mid-UNPACK (bit 3 of byte 40) → next cycle `ram_we` = 0 and all outputs are 0. A subsequent full frame completes normally starting at address 0.

Source files
------------

// File: rtl/snn_frame_ctrl.sv
// -----------------------------------------------------------------------------
// snn_frame_ctrl
//
// Frame-level controller for the SNN digit classifier.
//   - Unpacks received UART bytes LSB-first into the 1-bit input RAM, one bit
//     per cycle, and pulses start when the last image bit is written.
//   - Hands the RAM address to snn_core while the core is calculating.
//   - Captures the classified digit onto the LEDs and hands its ASCII code to
//     the UART transmitter.
//   - Recovers from stalled frames (timeout) and flags overrun bytes.
//
// Ports:
//   clk, rst             : system clock, synchronous active-high reset
//   rx_rdy, rx_data      : received byte strobe / data
//   ram_addr, ram_wdata,
//   ram_we               : input RAM write/read port (shared with snn_core)
//   core_addr            : read address from snn_core (used in CALC)
//   start                : one-cycle pulse launching snn_core
//   done, digit          : result strobe / classified digit from snn_core
//   tx_start, tx_data    : transmitter launch pulse / byte to send
//   tx_rdy               : transmitter idle
//   led                  : last classified digit
//   busy                 : high whenever the controller is not idle
//   frame_err            : sticky, a frame timed out
//   ovr_err              : sticky, a byte arrived while not accepting
// -----------------------------------------------------------------------------
module snn_frame_ctrl #(
  parameter int NUM_BITS = 784,
  parameter int ADDR_W   = 10,
  parameter int TIMEOUT  = 2_500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wdata,
  output logic              ram_we,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              start,
  input  logic              done,
  input  logic [3:0]        digit,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_rdy,
  output logic [7:0]        led,
  output logic              busy,
  output logic              frame_err,
  output logic              ovr_err
);

  // Idle counter is at least 22 bits wide, wider if TIMEOUT needs it.
  localparam int CNT_RAW = $clog2(TIMEOUT);
  localparam int CNT_W   = (CNT_RAW < 22) ? 22 : CNT_RAW;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BITS - 1);
  localparam logic [CNT_W-1:0]  IDLE_MAX  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_UNPACK    = 3'd1,
    S_WAIT_BYTE = 3'd2,
    S_CALC      = 3'd3,
    S_SEND      = 3'd4
  } state_t;

  state_t            state_q,     state_d;
  logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [7:0]        shreg_q,     shreg_d;
  logic [2:0]        bit_cnt_q,   bit_cnt_d;
  logic [CNT_W-1:0]  idle_cnt_q,  idle_cnt_d;
  logic [7:0]        led_q,       led_d;
  logic [7:0]        tx_data_q,   tx_data_d;
  logic              frame_err_q, frame_err_d;
  logic              ovr_err_q,   ovr_err_d;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      shreg_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      idle_cnt_q  <= '0;
      led_q       <= 8'h00;
      tx_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
      ovr_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      led_q       <= led_d;
      tx_data_q   <= tx_data_d;
      frame_err_q <= frame_err_d;
      ovr_err_q   <= ovr_err_d;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    led_d       = led_q;
    tx_data_d   = tx_data_q;
    frame_err_d = frame_err_q;
    ovr_err_d   = ovr_err_q;

    ram_addr  = wr_ptr_q;
    ram_we    = 1'b0;
    ram_wdata = 1'b0;
    start     = 1'b0;
    tx_start  = 1'b0;
    busy      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        wr_ptr_d  = '0;
        bit_cnt_d = 3'd0;
        if (rx_rdy) begin
          // First byte of a new frame clears the sticky error flags.
          shreg_d     = rx_data;
          frame_err_d = 1'b0;
          ovr_err_d   = 1'b0;
          state_d     = S_UNPACK;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_UNPACK: begin
        ram_we    = 1'b1;
        ram_wdata = shreg_q[0];
        shreg_d   = {1'b0, shreg_q[7:1]};
        wr_ptr_d  = wr_ptr_q + 1'b1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (rx_rdy) begin
          ovr_err_d = 1'b1;
        end else begin
          ovr_err_d = ovr_err_q;
        end
        if (bit_cnt_q == 3'd7) begin
          // The last image bit is written in the same cycle start fires.
          if (wr_ptr_q == LAST_ADDR) begin
            start   = 1'b1;
            state_d = S_CALC;
          end else begin
            idle_cnt_d = '0;
            state_d    = S_WAIT_BYTE;
          end
        end else begin
          state_d = S_UNPACK;
        end
      end

      S_WAIT_BYTE: begin
        // A byte arriving in the timeout cycle still wins.
        if (rx_rdy) begin
          shreg_d = rx_data;
          state_d = S_UNPACK;
        end else if (idle_cnt_q == IDLE_MAX) begin
          frame_err_d = 1'b1;
          wr_ptr_d    = '0;
          state_d     = S_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      S_CALC: begin
        ram_addr = core_addr;
        if (rx_rdy) begin
          ovr_err_d = 1'b1;
        end else begin
          ovr_err_d = ovr_err_q;
        end
        if (done) begin
          led_d     = {4'h0, digit};
          tx_data_d = 8'h30 + {4'h0, digit};
          state_d   = S_SEND;
        end else begin
          state_d = S_CALC;
        end
      end

      S_SEND: begin
        if (rx_rdy) begin
          ovr_err_d = 1'b1;
        end else begin
          ovr_err_d = ovr_err_q;
        end
        if (tx_rdy) begin
          tx_start = 1'b1;
          wr_ptr_d = '0;
          state_d  = S_IDLE;
        end else begin
          state_d = S_SEND;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign led       = led_q;
  assign tx_data   = tx_data_q;
  assign frame_err = frame_err_q;
  assign ovr_err   = ovr_err_q;

endmodule

// File: tb/tb_snn_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snn_frame_ctrl
//
// Self-checking bench for snn_frame_ctrl. A background monitor captures every
// RAM write into a shadow image; the expected image is derived from the frame
// bytes (address a holds bit a%8 of byte a/8). Result vectors come from a
// table plus random digits with the ASCII code computed arithmetically.
// -----------------------------------------------------------------------------
module tb_snn_frame_ctrl;

  localparam int NB     = 784;
  localparam int NBYTES = NB / 8;
  localparam int AW     = 10;
  localparam int TO     = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic [AW-1:0] ram_addr;
  logic          ram_wdata;
  logic          ram_we;
  logic [AW-1:0] core_addr;
  logic          start;
  logic          done;
  logic [3:0]    digit;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_rdy;
  logic [7:0]    led;
  logic          busy;
  logic          frame_err;
  logic          ovr_err;

  snn_frame_ctrl #(.NUM_BITS(NB), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .core_addr(core_addr), .start(start), .done(done), .digit(digit),
    .tx_start(tx_start), .tx_data(tx_data), .tx_rdy(tx_rdy), .led(led),
    .busy(busy), .frame_err(frame_err), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    dig;
    int            delay;
    logic [AW-1:0] caddr;
    logic [7:0]    exp_led;
    logic [7:0]    exp_tx;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   we_cnt    = 0;
  int   start_cnt = 0;
  int   txs_cnt   = 0;
  int   start_addr = 0;
  logic ram_img [1024];
  logic [7:0] frame [NBYTES];
  vec_t vecs [6];

  // Background monitor: shadow RAM and pulse counters.
  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt = we_cnt + 1;
      ram_img[ram_addr] = ram_wdata;
    end
    if (start) begin
      start_cnt  = start_cnt + 1;
      start_addr = int'(ram_addr);
    end
    if (tx_start) txs_cnt = txs_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse rx_rdy for one cycle; first write is expected the next cycle.
  task automatic send_byte(input logic [7:0] b, input int exp_addr);
    @(posedge clk); #1;
    rx_rdy  = 1'b1;
    rx_data = b;
    @(posedge clk); #1;
    rx_rdy  = 1'b0;
    rx_data = 8'($urandom);
    chk("first_we",   32'(ram_we),    32'd1);
    chk("first_addr", 32'(ram_addr),  32'(exp_addr));
    chk("first_bit",  32'(ram_wdata), 32'(b[0]));
    chk("busy_byte",  32'(busy),      32'd1);
  endtask

  // A byte that arrives while the controller is not accepting.
  task automatic inject();
    rx_rdy  = 1'b1;
    rx_data = 8'hEE;
    @(posedge clk); #1;
    rx_rdy  = 1'b0;
    chk("ovr_set", 32'(ovr_err), 32'd1);
  endtask

  task automatic send_frame(input int gmin, input int gmax, input bit ovr);
    int w0, s0, bad;
    w0 = we_cnt;
    s0 = start_cnt;
    for (int k = 0; k < NBYTES; k++) begin
      send_byte(frame[k], k * 8);
      if (k == 0) begin
        chk("ovr_clear",   32'(ovr_err),   32'd0);
        chk("frerr_clear", 32'(frame_err), 32'd0);
      end
      if (ovr && k == 10) inject();
      if (ovr && k == 20) begin
        repeat (7) @(posedge clk);
        #1;
        inject();
      end
      if (k < NBYTES - 1) repeat ($urandom_range(gmax, gmin)) @(posedge clk);
    end
    repeat (7) @(posedge clk);
    #1;
    chk("start_pulse", 32'(start),    32'd1);
    chk("start_addr",  32'(ram_addr), 32'(NB - 1));
    chk("start_we",    32'(ram_we),   32'd1);
    @(posedge clk); #1;
    chk("start_once",  32'(start),    32'd0);
    chk("calc_we",     32'(ram_we),   32'd0);
    chk("calc_busy",   32'(busy),     32'd1);
    chk("write_count", 32'(we_cnt - w0),    32'(NB));
    chk("start_count", 32'(start_cnt - s0), 32'd1);
    chk("start_mon",   32'(start_addr),     32'(NB - 1));
    bad = 0;
    for (int a = 0; a < NB; a++) begin
      if (ram_img[a] !== frame[a / 8][a % 8]) bad++;
    end
    chk("image", 32'(bad), 32'd0);
  endtask

  // Drive a result in CALC and follow it through SEND.
  task automatic result(input vec_t v);
    int t0;
    core_addr = v.caddr;
    #1;
    chk("calc_addr", 32'(ram_addr), 32'(v.caddr));
    chk("calc_we0",  32'(ram_we),   32'd0);
    t0     = txs_cnt;
    digit  = v.dig;
    done   = 1'b1;
    tx_rdy = (v.delay == 0);
    @(posedge clk); #1;
    done  = 1'b0;
    digit = 4'($urandom);
    chk("led",     32'(led),     32'(v.exp_led));
    chk("tx_data", 32'(tx_data), 32'(v.exp_tx));
    for (int i = 0; i < v.delay; i++) begin
      chk("bp_no_txstart", 32'(tx_start), 32'd0);
      chk("bp_busy",       32'(busy),     32'd1);
      @(posedge clk); #1;
    end
    tx_rdy = 1'b1;
    @(negedge clk);
    chk("tx_start",     32'(tx_start), 32'd1);
    chk("tx_data_send", 32'(tx_data),  32'(v.exp_tx));
    @(posedge clk); #1;
    chk("tx_start_end", 32'(tx_start), 32'd0);
    chk("busy_end",     32'(busy),     32'd0);
    chk("tx_count",     32'(txs_cnt - t0), 32'd1);
    chk("tx_data_hold", 32'(tx_data),  32'(v.exp_tx));
    tx_rdy = 1'($urandom);
  endtask

  task automatic rand_frame();
    for (int k = 0; k < NBYTES; k++) frame[k] = 8'($urandom);
  endtask

  function automatic vec_t model(input logic [3:0] d, input int delay);
    vec_t v;
    v.dig     = d;
    v.delay   = delay;
    v.caddr   = AW'($urandom);
    v.exp_led = 8'(int'(d));
    v.exp_tx  = 8'(48 + int'(d));
    return v;
  endfunction

  initial begin
    vecs[0] = '{4'd7,  0,  10'h155, 8'h07, 8'h37};
    vecs[1] = '{4'd3,  50, 10'h0AA, 8'h03, 8'h33};
    vecs[2] = '{4'd0,  2,  10'h3FF, 8'h00, 8'h30};
    vecs[3] = '{4'd9,  0,  10'h001, 8'h09, 8'h39};
    vecs[4] = '{4'd10, 1,  10'h200, 8'h0A, 8'h3A};
    vecs[5] = '{4'd15, 3,  10'h30F, 8'h0F, 8'h3F};

    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; core_addr = '0;
    done = 1'b0; digit = 4'h0; tx_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_we",   32'(ram_we),   32'd0);
    chk("rst_busy", 32'(busy),     32'd0);
    chk("rst_led",  32'(led),      32'd0);
    chk("rst_tx",   32'(tx_data),  32'd0);
    chk("rst_err",  32'({frame_err, ovr_err, start, tx_start}), 32'd0);
    rst = 1'b0;

    // Directed frame: byte k = k, ~100 cycles apart, digit 7.
    for (int k = 0; k < NBYTES; k++) frame[k] = 8'(k);
    send_frame(99, 99, 1'b0);
    result(vecs[0]);

    // done outside CALC is ignored.
    digit = 4'd5; done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    chk("done_ignored_led", 32'(led),      32'h07);
    chk("done_ignored_tx",  32'(tx_data),  32'h37);
    chk("done_ignored_bsy", 32'(busy),     32'd0);
    chk("done_ignored_txs", 32'(tx_start), 32'd0);

    // Table-driven result vectors, each behind a random frame.
    for (int i = 1; i < 6; i++) begin
      rand_frame();
      send_frame(7, 12, i == 2);
      if (i == 3) begin
        chk("ovr_pre_calc", 32'(ovr_err), 32'd0);
        inject();
        chk("ovr_calc_busy", 32'(busy), 32'd1);
      end
      result(vecs[i]);
    end

    // Timeout: byte 5 lands exactly on the timeout cycle and wins.
    rand_frame();
    for (int k = 0; k < 10; k++) begin
      send_byte(frame[k], k * 8);
      chk("to_no_err", 32'(frame_err), 32'd0);
      if (k == 4) repeat (TO + 6) @(posedge clk);
      else if (k < 9) repeat (7) @(posedge clk);
    end
    repeat (TO + 7) @(posedge clk);
    #1;
    chk("to_before", 32'(frame_err), 32'd0);
    chk("to_busy",   32'(busy),      32'd1);
    @(posedge clk); #1;
    chk("to_err",    32'(frame_err), 32'd1);
    chk("to_idle",   32'(busy),      32'd0);
    chk("to_addr",   32'(ram_addr),  32'd0);

    // Next byte restarts at address 0; then reset at bit 3 of byte 40.
    send_byte(frame[0], 0);
    chk("to_err_clear", 32'(frame_err), 32'd0);
    for (int k = 1; k <= 40; k++) begin
      repeat (7) @(posedge clk);
      send_byte(frame[k], k * 8);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("mid_addr", 32'(ram_addr), 32'd323);
    chk("mid_we",   32'(ram_we),   32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_we",   32'(ram_we),    32'd0);
    chk("mrst_addr", 32'(ram_addr),  32'd0);
    chk("mrst_bit",  32'(ram_wdata), 32'd0);
    chk("mrst_led",  32'(led),       32'd0);
    chk("mrst_tx",   32'(tx_data),   32'd0);
    chk("mrst_busy", 32'(busy),      32'd0);
    chk("mrst_flags", 32'({frame_err, ovr_err, start, tx_start}), 32'd0);
    rst = 1'b0;
    rand_frame();
    send_frame(7, 15, 1'b0);
    result(model(4'($urandom), 0));

    // Randomized frames and results against the model.
    for (int r = 0; r < 3; r++) begin
      rand_frame();
      send_frame(7, 40, 1'($urandom));
      result(model(4'($urandom), int'($urandom_range(6, 0))));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
